lock_supervisor: RTL and testbench

LOCK_SUPERVISOR -- requirements
Module: lock_supervisor

---
 rtl/lock_pkg.sv | 19 +
 rtl/lock_timer.sv | 28 ++
 rtl/lock_supervisor.sv | 159 +++++++++++++++
 tb/tb_lock_supervisor.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared state encodings and default settings for the lock supervisor
// and the seven-segment state decoder.
package lock_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ENTRY   = 3'd1;
    localparam logic [2:0] ST_CHECK   = 3'd2;
    localparam logic [2:0] ST_OPEN    = 3'd3;
    localparam logic [2:0] ST_LOCKOUT = 3'd4;
    localparam logic [2:0] ST_PROGRAM = 3'd5;

    localparam int         DEF_CODE_LEN   = 6;
    localparam logic [5:0] DEF_CODE       = 6'b010110;
    localparam int         DEF_MAX_FAIL   = 3;
    localparam int         DEF_OPEN_TICKS = 5;
    localparam int         DEF_LOCK_TICKS = 10;
    localparam int         DEF_IDLE_TICKS = 4;

endpackage

// File: rtl/lock_timer.sv
// Tick-enabled up-counter with synchronous clear; done pulses on the tick
// that brings the count up to the limit.
module lock_timer #(
    parameter int W = 4
) (
    input  logic         clk_100Mhz,
    input  logic         reset,
    input  logic         tick,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk_100Mhz or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (tick && (count < limit)) begin
            count <= count + W'(1);
        end
    end

    assign done = tick && ((count + W'(1)) == limit);

endmodule

// File: rtl/lock_supervisor.sv
// Code-entry lock controller: serial code entry, compare, timed unlock,
// failure lockout and in-field reprogramming of the code.
module lock_supervisor
    import lock_pkg::*;
#(
    parameter int                  CODE_LEN     = DEF_CODE_LEN,
    parameter logic [CODE_LEN-1:0] DEFAULT_CODE = DEF_CODE,
    parameter int                  MAX_FAIL     = DEF_MAX_FAIL,
    parameter int                  OPEN_TICKS   = DEF_OPEN_TICKS,
    parameter int                  LOCK_TICKS   = DEF_LOCK_TICKS,
    parameter int                  IDLE_TICKS   = DEF_IDLE_TICKS
) (
    input  logic       clk_100Mhz,
    input  logic       reset,
    input  logic       tick,
    input  logic       bit_valid,
    input  logic       bit_val,
    input  logic       prog_req,
    output logic       unlock,
    output logic       alarm,
    output logic [1:0] fail_cnt,
    output logic [2:0] state_code
);

    localparam int MAX_OI = (OPEN_TICKS > IDLE_TICKS) ? OPEN_TICKS : IDLE_TICKS;
    localparam int MAX_T  = (LOCK_TICKS > MAX_OI) ? LOCK_TICKS : MAX_OI;
    localparam int T_W    = $clog2(MAX_T + 1);
    localparam int BC_W   = $clog2(CODE_LEN + 1);

    logic [2:0]          state, state_nx;
    logic [CODE_LEN-1:0] shreg, shreg_nx, code, code_nx, shifted;
    logic [BC_W-1:0]     bit_cnt, bit_cnt_nx;
    logic [1:0]          fail_nx;
    logic                unlock_nx, alarm_nx, last_bit;
    logic [T_W-1:0]      limit;
    logic                timer_clr, timer_done;

    // One shift register serves both code entry and reprogramming; it is
    // always empty whenever the FSM sits in IDLE or OPEN.
    assign shifted  = {shreg[CODE_LEN-2:0], bit_val};
    assign last_bit = (bit_cnt + BC_W'(1)) == BC_W'(CODE_LEN);

    always_comb begin
        case (state)
            ST_OPEN:    limit = T_W'(OPEN_TICKS);
            ST_LOCKOUT: limit = T_W'(LOCK_TICKS);
            default:    limit = T_W'(IDLE_TICKS);
        endcase
    end

    assign timer_clr = (state_nx != state) || (state == ST_IDLE) ||
                       (bit_valid && ((state == ST_ENTRY) || (state == ST_PROGRAM)));

    lock_timer #(.W(T_W)) u_timer (
        .clk_100Mhz (clk_100Mhz),
        .reset      (reset),
        .tick       (tick),
        .clr        (timer_clr),
        .limit      (limit),
        .done       (timer_done)
    );

    always_comb begin
        state_nx   = state;
        shreg_nx   = shreg;
        bit_cnt_nx = bit_cnt;
        code_nx    = code;
        fail_nx    = fail_cnt;
        case (state)
            ST_IDLE: begin
                if (bit_valid) begin
                    shreg_nx   = CODE_LEN'(bit_val);
                    bit_cnt_nx = BC_W'(1);
                    state_nx   = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                // A bit arriving on the timeout tick wins and keeps the entry alive.
                if (bit_valid) begin
                    shreg_nx   = shifted;
                    bit_cnt_nx = bit_cnt + BC_W'(1);
                    if (last_bit) state_nx = ST_CHECK;
                end else if (timer_done) begin
                    shreg_nx   = '0;
                    bit_cnt_nx = '0;
                    state_nx   = ST_IDLE;
                end
            end
            ST_CHECK: begin
                shreg_nx   = '0;
                bit_cnt_nx = '0;
                if (shreg == code) begin
                    fail_nx  = '0;
                    state_nx = ST_OPEN;
                end else begin
                    fail_nx  = fail_cnt + 2'd1;
                    state_nx = (fail_nx == 2'(MAX_FAIL)) ? ST_LOCKOUT : ST_IDLE;
                end
            end
            ST_OPEN: begin
                if (prog_req)        state_nx = ST_PROGRAM;
                else if (timer_done) state_nx = ST_IDLE;
            end
            ST_PROGRAM: begin
                if (bit_valid) begin
                    shreg_nx   = shifted;
                    bit_cnt_nx = bit_cnt + BC_W'(1);
                    if (last_bit) begin
                        code_nx    = shifted;
                        shreg_nx   = '0;
                        bit_cnt_nx = '0;
                        state_nx   = ST_IDLE;
                    end
                end else if (timer_done) begin
                    shreg_nx   = '0;
                    bit_cnt_nx = '0;
                    state_nx   = ST_IDLE;
                end
            end
            ST_LOCKOUT: begin
                if (timer_done) begin
                    fail_nx  = '0;
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                shreg_nx   = '0;
                bit_cnt_nx = '0;
                fail_nx    = '0;
                state_nx   = ST_IDLE;
            end
        endcase
        unlock_nx = (state_nx == ST_OPEN) || (state_nx == ST_PROGRAM);
        alarm_nx  = (state_nx == ST_LOCKOUT);
    end

    always_ff @(posedge clk_100Mhz or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            code     <= DEFAULT_CODE;
            fail_cnt <= '0;
            unlock   <= 1'b0;
            alarm    <= 1'b0;
        end else begin
            state    <= state_nx;
            shreg    <= shreg_nx;
            bit_cnt  <= bit_cnt_nx;
            code     <= code_nx;
            fail_cnt <= fail_nx;
            unlock   <= unlock_nx;
            alarm    <= alarm_nx;
        end
    end

    assign state_code = state;

endmodule

// File: tb/tb_lock_supervisor.sv
// Directed bench for lock_supervisor: entry, lockout, timeouts,
// reprogramming and asynchronous reset recovery.
module tb_lock_supervisor;

    logic       clk_100Mhz = 1'b0;
    logic       reset      = 1'b1;
    logic       tick       = 1'b0;
    logic       bit_valid  = 1'b0;
    logic       bit_val    = 1'b0;
    logic       prog_req   = 1'b0;
    logic       unlock, alarm;
    logic [1:0] fail_cnt;
    logic [2:0] state_code;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_100Mhz = ~clk_100Mhz;

    lock_supervisor #(
        .CODE_LEN     (6),
        .DEFAULT_CODE (6'b010110),
        .MAX_FAIL     (3),
        .OPEN_TICKS   (5),
        .LOCK_TICKS   (10),
        .IDLE_TICKS   (4)
    ) dut (
        .clk_100Mhz (clk_100Mhz),
        .reset      (reset),
        .tick       (tick),
        .bit_valid  (bit_valid),
        .bit_val    (bit_val),
        .prog_req   (prog_req),
        .unlock     (unlock),
        .alarm      (alarm),
        .fail_cnt   (fail_cnt),
        .state_code (state_code)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge capture them, return at edge+1.
    task automatic step(input logic t, input logic bv, input logic b);
        tick = t; bit_valid = bv; bit_val = b;
        @(posedge clk_100Mhz);
        #1;
        tick = 1'b0; bit_valid = 1'b0; bit_val = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic send_code(input logic [5:0] c, input int gap, input logic t_on_bit);
        for (int i = 5; i >= 0; i--) begin
            step(t_on_bit, 1'b1, c[i]);
            if (i > 0) ticks(gap);
        end
    endtask

    initial begin
        #1 reset = 1'b0;
        #2;
        chk("rst_state", int'(state_code), 0);
        chk("rst_unlock", int'(unlock), 0);
        chk("rst_alarm", int'(alarm), 0);
        chk("rst_fail", int'(fail_cnt), 0);
        #9 reset = 1'b1;

        // correct code, one bit per 3 ticks
        send_code(6'b010110, 3, 1'b0);
        chk("ok_check_state", int'(state_code), 2);
        step(1'b0, 1'b0, 1'b0);
        chk("ok_open_state", int'(state_code), 3);
        chk("ok_open_unlock", int'(unlock), 1);
        chk("ok_open_fail", int'(fail_cnt), 0);
        chk("ok_open_alarm", int'(alarm), 0);
        for (int i = 1; i <= 5; i++) begin
            ticks(1);
            chk("open_hold_unlock", int'(unlock), (i < 5) ? 1 : 0);
        end
        chk("open_expired_state", int'(state_code), 0);

        // three wrong attempts -> lockout
        send_code(6'b111111, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("wrong1_state", int'(state_code), 0);
        chk("wrong1_fail", int'(fail_cnt), 1);
        send_code(6'b111111, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("wrong2_fail", int'(fail_cnt), 2);
        send_code(6'b111111, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("lock_state", int'(state_code), 4);
        chk("lock_alarm", int'(alarm), 1);
        chk("lock_unlock", int'(unlock), 0);
        chk("lock_fail", int'(fail_cnt), 3);
        prog_req = 1'b1;
        step(1'b0, 1'b1, 1'b1);
        prog_req = 1'b0;
        chk("lock_ignores_input", int'(state_code), 4);
        ticks(9);
        chk("lock_hold_alarm", int'(alarm), 1);
        ticks(1);
        chk("lock_end_state", int'(state_code), 0);
        chk("lock_end_alarm", int'(alarm), 0);
        chk("lock_end_fail", int'(fail_cnt), 0);

        // entry inactivity timeout keeps the failure count
        send_code(6'b111111, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("pre_timeout_fail", int'(fail_cnt), 1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        chk("partial_entry_state", int'(state_code), 1);
        ticks(3);
        chk("timeout_not_yet", int'(state_code), 1);
        ticks(1);
        chk("timeout_state", int'(state_code), 0);
        chk("timeout_fail_kept", int'(fail_cnt), 1);
        send_code(6'b010110, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("after_timeout_open", int'(state_code), 3);
        chk("after_timeout_fail", int'(fail_cnt), 0);
        ticks(5);

        // reprogram to 001100; prog_req beats the final OPEN tick
        send_code(6'b010110, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        ticks(4);
        chk("open_before_prog", int'(unlock), 1);
        prog_req = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        prog_req = 1'b0;
        chk("prog_wins_tick", int'(state_code), 5);
        chk("prog_unlock", int'(unlock), 1);
        send_code(6'b001100, 0, 1'b0);
        chk("prog_done_state", int'(state_code), 0);
        chk("prog_done_unlock", int'(unlock), 0);
        send_code(6'b010110, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("old_code_fails", int'(state_code), 0);
        chk("old_code_fail_cnt", int'(fail_cnt), 1);
        send_code(6'b001100, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("new_code_opens", int'(state_code), 3);
        chk("new_code_fail_cnt", int'(fail_cnt), 0);
        ticks(5);

        // programming aborted by inactivity leaves the code alone
        send_code(6'b001100, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        prog_req = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        prog_req = 1'b0;
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        ticks(3);
        chk("prog_wait_state", int'(state_code), 5);
        ticks(1);
        chk("prog_abort_state", int'(state_code), 0);
        chk("prog_abort_unlock", int'(unlock), 0);
        send_code(6'b001100, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("code_kept_after_abort", int'(state_code), 3);
        ticks(5);

        // reset during lockout
        repeat (3) begin
            send_code(6'b111111, 0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
        chk("lock2_state", int'(state_code), 4);
        ticks(3);
        #2 reset = 1'b0;
        #1;
        chk("rst_lock_state", int'(state_code), 0);
        chk("rst_lock_alarm", int'(alarm), 0);
        chk("rst_lock_fail", int'(fail_cnt), 0);
        #3 reset = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        chk("rst_release_state", int'(state_code), 0);
        send_code(6'b010110, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("default_code_restored", int'(state_code), 3);

        // reset during programming bit 4
        prog_req = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        prog_req = 1'b0;
        chk("prog2_state", int'(state_code), 5);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("rst_prog_state", int'(state_code), 0);
        chk("rst_prog_unlock", int'(unlock), 0);
        #3 reset = 1'b1;
        send_code(6'b010110, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("default_after_prog_reset", int'(state_code), 3);
        ticks(5);

        // every entry bit coincides with a tick
        send_code(6'b010110, 3, 1'b1);
        chk("tick_bits_check", int'(state_code), 2);
        step(1'b0, 1'b0, 1'b0);
        chk("tick_bits_open", int'(state_code), 3);
        ticks(5);
        chk("tick_bits_idle", int'(state_code), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
